// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line typedefs plus the physical-memory responder state and latency.
`timescale 1ns/1ps
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;

    // Default request-to-response latency of the physical memory model
    localparam int unsigned PMEM_LATENCY = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage: 2^INDEX_BITS lines of 128 bits, synchronous write, combinational read.
// Contents are intentionally not reset.
`timescale 1ns/1ps
module pmem_line_array
    import lc3b_types::*;
#(
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] waddr_i,
    input  lc3b_data              wdata_i,
    input  logic [INDEX_BITS-1:0] raddr_i,
    output lc3b_data              rdata_o
);

    localparam int unsigned Lines = 1 << INDEX_BITS;

    lc3b_data mem_q [Lines];

    // Write port: one line per cycle when enabled
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency physical memory responder: accepts one line read or write, answers with a
// single-cycle pmem_resp LATENCY cycles later, and flags simultaneous read/write as an error.
`timescale 1ns/1ps
module pmem_responder
    import lc3b_types::*;
#(
    parameter int unsigned LATENCY    = PMEM_LATENCY,
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     pmem_read,
    input  logic     pmem_write,
    input  lc3b_word pmem_address,
    input  lc3b_data pmem_wdata,
    output lc3b_data pmem_rdata,
    output logic     pmem_resp,
    output logic     pmem_error
);

    localparam int unsigned CntW = 4;

    pmem_state_t           state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    lc3b_data              wdata_q, wdata_d;
    lc3b_data              rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic [INDEX_BITS-1:0] addr_idx;
    lc3b_data              line_rdata;
    logic                  line_we;
    logic                  unused_addr;

    // Offset bits and high bits beyond the index alias away
    assign addr_idx    = pmem_address[INDEX_BITS+3:4];
    assign unused_addr = ^pmem_address;

    // Next-state logic: accept, count down, respond
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        error_d = error_q;
        unique case (state_q)
            StIdle: begin
                if (pmem_read ^ pmem_write) begin
                    op_wr_d = pmem_write;
                    idx_d   = addr_idx;
                    wdata_d = pmem_wdata;
                    if (LATENCY <= 1) begin
                        state_d = StResp;
                        cnt_d   = '0;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntW'(LATENCY - 1);
                    end
                end else if (pmem_read && pmem_write) begin
                    error_d = 1'b1;
                end
            end
            StBusy: begin
                // Leave on the edge that brings the counter to zero
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Read data is captured only on entry to RESP, so it is zero in every other cycle
    always_comb begin
        rdata_d = '0;
        if ((state_d == StResp) && !op_wr_d) begin
            rdata_d = line_rdata;
        end
    end

    // State, counter and request latches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Write commits on the edge that ends RESP; a reset before then drops it
    assign line_we = (state_q == StResp) && op_wr_q;

    pmem_line_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_line_array (
        .clk_i  (clk),
        .we_i   (line_we),
        .waddr_i(idx_q),
        .wdata_i(wdata_q),
        .raddr_i(idx_d),
        .rdata_o(line_rdata)
    );

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = (state_q == StResp);
    assign pmem_error = error_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: one instance at LATENCY=4, one at LATENCY=1.
`timescale 1ns/1ps
module tb_pmem_responder;
    import lc3b_types::*;

    logic     clk;
    logic     reset_n;
    logic     rd    [2];
    logic     wr    [2];
    lc3b_word addr  [2];
    lc3b_data wd    [2];
    lc3b_data rdata [2];
    logic     resp  [2];
    logic     err   [2];

    int unsigned chk_cnt = 0;
    int unsigned err_cnt = 0;

    lc3b_data sb_q [$];
    lc3b_data model [int];

    pmem_responder #(
        .LATENCY   (4),
        .INDEX_BITS(8)
    ) u_dut_l4 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pmem_read   (rd[0]),
        .pmem_write  (wr[0]),
        .pmem_address(addr[0]),
        .pmem_wdata  (wd[0]),
        .pmem_rdata  (rdata[0]),
        .pmem_resp   (resp[0]),
        .pmem_error  (err[0])
    );

    pmem_responder #(
        .LATENCY   (1),
        .INDEX_BITS(8)
    ) u_dut_l1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pmem_read   (rd[1]),
        .pmem_write  (wr[1]),
        .pmem_address(addr[1]),
        .pmem_wdata  (wd[1]),
        .pmem_rdata  (rdata[1]),
        .pmem_resp   (resp[1]),
        .pmem_error  (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int key(input int d, input lc3b_word a);
        return d * 4096 + int'(a[11:4]);
    endfunction

    // One complete transaction; chg scrambles address/data and drop deasserts after one cycle
    task automatic transact(input int d, input bit is_wr, input lc3b_word a, input lc3b_data data,
                            input bit chg, input bit drop);
        int  lat;
        bit  seen;
        lat  = (d == 0) ? 4 : 1;
        seen = 1'b0;
        @(negedge clk);
        check("idle_resp", resp[d], 1'b0);
        rd[d]   = !is_wr;
        wr[d]   = is_wr;
        addr[d] = a;
        wd[d]   = data;
        if (!is_wr) sb_q.push_back(model.exists(key(d, a)) ? model[key(d, a)] : '0);
        @(posedge clk);
        for (int j = 0; j < 40 && !seen; j++) begin
            @(negedge clk);
            if (resp[d]) begin
                seen  = 1'b1;
                rd[d] = 1'b0;
                wr[d] = 1'b0;
                check("latency", 128'(j), 128'(lat - 1));
                if (!is_wr) check("rdata", rdata[d], sb_q.pop_front());
            end else begin
                if (j == lat - 2) check("rdata_pre_resp", rdata[d], '0);
                if (j == 0 && chg) begin
                    addr[d] = 16'h0000;
                    wd[d]   = ~data;
                end
                if (j == 0 && drop) begin
                    rd[d] = 1'b0;
                    wr[d] = 1'b0;
                end
            end
        end
        if (!seen) begin
            check("resp_timeout", 1'b0, 1'b1);
            rd[d] = 1'b0;
            wr[d] = 1'b0;
            if (!is_wr && sb_q.size() > 0) void'(sb_q.pop_front());
        end
        if (is_wr) model[key(d, a)] = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lc3b_data d1;
        lc3b_data d2;
        int       nresp;
        bit       seen;
        lc3b_word ra [4];
        lc3b_data rv [4];

        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
        end
        #3;
        check("rst_resp", resp[0], 1'b0);
        check("rst_rdata", rdata[0], '0);
        check("rst_error", err[0], 1'b0);
        check("rst_resp_l1", resp[1], 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Write then read of the same line at a different offset
        transact(0, 1'b1, 16'h0040, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 1'b0);
        transact(0, 1'b0, 16'h004C, '0, 1'b0, 1'b0);

        // Address change after acceptance, and aliasing of 0x1230 onto line 0x23
        transact(0, 1'b1, 16'h0230, 128'hDEADBEEF_00000023_CAFEF00D_12345678, 1'b0, 1'b0);
        transact(0, 1'b1, 16'h0000, 128'h11111111_22222222_33333333_44444444, 1'b0, 1'b0);
        transact(0, 1'b0, 16'h1230, '0, 1'b1, 1'b0);

        // Write with address/data scrambled after acceptance, then read back
        transact(0, 1'b1, 16'h0350, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1'b1, 1'b0);
        transact(0, 1'b0, 16'h0350, '0, 1'b0, 1'b0);
        transact(0, 1'b0, 16'h0000, '0, 1'b0, 1'b0);

        // Request dropped during BUSY still completes
        transact(0, 1'b0, 16'h0040, '0, 1'b0, 1'b1);

        // Random lines
        for (int i = 0; i < 4; i++) begin
            ra[i] = lc3b_word'($urandom_range(0, 16'hFFFF));
            ra[i][11:8] = 4'(i + 8);
            rv[i] = {$urandom, $urandom, $urandom, $urandom};
            transact(0, 1'b1, ra[i], rv[i], 1'b0, 1'b0);
        end
        for (int i = 3; i >= 0; i--) transact(0, 1'b0, ra[i], '0, 1'b0, 1'b0);

        // Reset two cycles into a write must not touch storage
        d1 = 128'h00000000_FFFFFFFF_00000000_80808080;
        d2 = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
        transact(0, 1'b1, 16'h0080, d1, 1'b0, 1'b0);
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 16'h0080; wd[0] = d2;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        wr[0] = 1'b0;
        #1;
        check("abort_resp", resp[0], 1'b0);
        check("abort_rdata", rdata[0], '0);
        @(negedge clk);
        @(negedge clk);
        check("abort_resp_held", resp[0], 1'b0);
        reset_n = 1'b1;
        transact(0, 1'b0, 16'h0080, '0, 1'b0, 1'b0);

        // Reset during a read response clears resp and rdata at once
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 16'h0230;
        seen = 1'b0;
        for (int j = 0; j < 20 && !seen; j++) begin
            @(negedge clk);
            if (resp[0]) seen = 1'b1;
        end
        check("rsp_seen", seen, 1'b1);
        check("rsp_rdata", rdata[0], model[key(0, 16'h0230)]);
        #1 reset_n = 1'b0;
        rd[0] = 1'b0;
        #1;
        check("rsp_rst_resp", resp[0], 1'b0);
        check("rsp_rst_rdata", rdata[0], '0);
        @(negedge clk);
        reset_n = 1'b1;

        // LATENCY=1 back-to-back write then read
        transact(1, 1'b1, 16'h0100, 128'hFEEDFACE_0BADF00D_13579BDF_2468ACE0, 1'b0, 1'b0);
        transact(1, 1'b0, 16'h0100, '0, 1'b0, 1'b0);
        transact(1, 1'b1, 16'h0FF0, 128'h1, 1'b0, 1'b0);
        transact(1, 1'b0, 16'hFFF8, '0, 1'b0, 1'b0);

        // Read and write together: no response, sticky error
        @(negedge clk);
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0040;
        nresp = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (resp[0]) nresp++;
        end
        check("both_no_resp", 128'(nresp), 128'd0);
        check("both_error", err[0], 1'b1);
        rd[0] = 1'b0; wr[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("both_error_sticky", err[0], 1'b1);
        check("both_resp_quiet", resp[0], 1'b0);
        check("other_error", err[1], 1'b0);
        transact(0, 1'b0, 16'h004C, '0, 1'b0, 1'b0);
        check("error_after_txn", err[0], 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("error_reset", err[0], 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        check("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning the number of cycles from request acceptance to pmem_resp (legal range 1..15).
REQ-002 SHALL have parameter INDEX_BITS, default 8, meaning the log2 of the number of 128-bit lines stored.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pmem_read, input, 1 bit: line read request, held by the requester until pmem_resp.
REQ-006 SHALL have port pmem_write, input, 1 bit: line write request, held by the requester until pmem_resp.
REQ-007 SHALL have port pmem_address, input, lc3b_word (16 bits): byte address; bits [3:0] are ignored.
REQ-008 SHALL have port pmem_wdata, input, lc3b_data (128 bits): write line data.
REQ-009 SHALL have port pmem_rdata, output, lc3b_data (128 bits): read line data, valid only while pmem_resp is high after a read.
REQ-010 SHALL have port pmem_resp, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port pmem_error, output, 1 bit: sticky protocol-violation flag.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-013 IDLE: on an edge where exactly one of pmem_read or pmem_write is high, SHALL latch op, line index pmem_address[INDEX_BITS+3:4] and pmem_wdata, load the counter with LATENCY-1, and go to BUSY; if LATENCY=1, SHALL go directly to RESP.
REQ-014 BUSY: SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-015 RESP: SHALL drive pmem_resp=1 for exactly one cycle, then return to IDLE.
REQ-016 Latency: a request sampled at edge N SHALL produce pmem_resp high during the cycle following edge N+LATENCY-1.
REQ-017 Read: pmem_rdata SHALL be registered, equal to storage[latched index] throughout the RESP cycle, and 0 in every other cycle.
REQ-018 Write: storage[latched index] SHALL be updated with the latched wdata on the edge that ends the RESP cycle.
REQ-019 Read-after-write to the same line SHALL return the new data.
REQ-020 Changes to pmem_address or pmem_wdata after acceptance SHALL be ignored.
REQ-021 Request deasserted during BUSY: the transaction SHALL still complete and pmem_resp SHALL still pulse.
REQ-022 Back-to-back requests: a request still asserted in the first IDLE cycle after RESP SHALL be accepted as a new transaction, so the requester must drop it on the pmem_resp edge.
REQ-023 pmem_read and pmem_write both high in IDLE SHALL cause no acceptance and no response, and SHALL set pmem_error=1, which stays set until reset.
REQ-024 Addresses SHALL alias modulo 2^INDEX_BITS lines; no out-of-range error is raised.

Reset
REQ-025 reset_n low SHALL immediately force state=IDLE, pmem_resp=0, pmem_rdata=0, pmem_error=0 and counter=0, including in the middle of a transaction.
REQ-026 An in-flight write aborted by reset SHALL NOT modify storage.
REQ-027 Storage contents SHALL NOT be reset; they are undefined until written.

Structure
REQ-028 The FSM state enum (pmem_state_t) and the default latency constant PMEM_LATENCY SHALL be added to the shared package lc3b_types; lc3b_word and lc3b_data come from that package.
REQ-029 Line storage SHALL be a single sub-module, pmem_line_array: 2^INDEX_BITS x 128 bits, synchronous write, combinational read.
REQ-030 The FSM, counter and latches SHALL reside in pmem_responder.

Verification
REQ-031 Write 0x0123456789ABCDEF_FEDCBA9876543210 to 0x0040, then read 0x004C -> read pmem_resp exactly 4 cycles after acceptance, pmem_rdata equals the written line.
REQ-032 Read 0x1230, change the address to 0x0000 after 1 cycle -> data returned is that of line 0x123 (mod 256 = 0x23).
REQ-033 Assert pmem_read and pmem_write together for 10 cycles -> pmem_resp stays 0, pmem_error=1 and stays set afterwards.
REQ-034 Assert reset_n low 2 cycles into a write to 0x0080 -> pmem_resp=0 immediately; a later read of 0x0080 returns the prior contents.
REQ-035 LATENCY=1: read-after-write to 0x0100 back-to-back -> each pmem_resp arrives 1 cycle after acceptance, read returns the written data.
